store_buffer: RTL

//  - Posted-write FIFO between the MEM stage and the data memory. Stores retire in 1 cycle even when the memory side is slow.
//  - Loads bypass the queue and have priority on the single memory address bus.
//  - Loads are served by forwarding from pending stores when their word address matches.
//  - Drives the data memory's clk/we/a/wd interface. Consumes its combinational read data.

---
 rtl/sb_pkg.sv | 27 ++
 rtl/sb_match.sv | 45 ++++
 rtl/store_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared types and sizing helpers for the store buffer.
//   sb_entry_t   : one pending store (word address + data) at the default widths
//   sb_ptr_w()   : head/tail pointer width for a given depth
//   sb_cnt_w()   : occupancy counter width for a given depth (must hold DEPTH)
package sb_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_AW_DEF    = 32;
  localparam int SB_DW_DEF    = 32;

  localparam int SB_PTR_W_DEF = $clog2(SB_DEPTH_DEF);
  localparam int SB_CNT_W_DEF = $clog2(SB_DEPTH_DEF + 1);

  typedef struct packed {
    logic [SB_AW_DEF-3:0] waddr;
    logic [SB_DW_DEF-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Address match for the store buffer entry array.
// Ports:
//   waddr        in   per-entry word address
//   valid        in   per-entry valid mask
//   head         in   index of the oldest entry
//   query        in   word address being looked up
//   hit          out  per-entry match mask (valid && address equal)
//   youngest_idx out  index of the youngest matching entry
//   any_hit      out  at least one entry matches
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int WAW   = SB_AW_DEF - 2,
  parameter int PTR_W = SB_PTR_W_DEF
) (
  input  logic [WAW-1:0]   waddr [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W-1:0] head,
  input  logic [WAW-1:0]   query,
  output logic [DEPTH-1:0] hit,
  output logic [PTR_W-1:0] youngest_idx,
  output logic             any_hit
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] && (waddr[i] == query);
    end
    any_hit = |hit;
  end

  // Walk from oldest to youngest; the last hit seen is the youngest.
  always_comb begin
    youngest_idx = head;
    idx          = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (hit[idx]) youngest_idx = idx;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a data memory.
// Stores retire in one cycle into a circular queue; the queue drains to
// memory whenever the shared address bus is not needed by a load.
// Optional feature macro: STORE_FWD_EN
//   defined   : loads hitting pending stores get the youngest matching data
//   undefined : such loads stall until every matching store has drained
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   cpu_we/cpu_re          store / load request
//   cpu_a, cpu_wd, cpu_rd  byte address, store data, load data
//   cpu_stall              hold the current MEM-stage request
//   mem_ready              memory can accept a write this cycle
//   mem_we, mem_a, mem_wd  memory write strobe, shared address, write data
//   mem_rd                 memory combinational read data
//   sb_empty, sb_full      occupancy flags
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = SB_AW_DEF,
  parameter int DW    = SB_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          sb_empty,
  output logic          sb_full
);

  localparam int PTR_W = sb_ptr_w(DEPTH);
  localparam int CNT_W = sb_cnt_w(DEPTH);
  localparam int WAW   = AW - 2;

  typedef struct packed {
    logic [WAW-1:0] waddr;
    logic [DW-1:0]  data;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [WAW-1:0]   ent_waddr [DEPTH];
  logic [WAW-1:0]   query;
  logic [DEPTH-1:0] hit;
  logic [PTR_W-1:0] youngest_idx;
  logic             any_hit;

  logic load_req;
  logic is_full;
  logic is_empty;
  logic fwd_hazard_stall;
  logic drain_fire;
  logic enq_fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_waddr[i] = entries[i].waddr;
    end
  end

  assign query = cpu_a[AW-1:2];

  sb_match #(
    .DEPTH(DEPTH),
    .WAW  (WAW),
    .PTR_W(PTR_W)
  ) u_match (
    .waddr       (ent_waddr),
    .valid       (valid),
    .head        (head),
    .query       (query),
    .hit         (hit),
    .youngest_idx(youngest_idx),
    .any_hit     (any_hit)
  );

  // A store issued together with a load wins; the load is dropped.
  assign load_req = cpu_re && !cpu_we;
  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);

`ifdef STORE_FWD_EN
  assign fwd_hazard_stall = 1'b0;
  assign cpu_rd = any_hit ? entries[youngest_idx].data : mem_rd;
`else
  assign fwd_hazard_stall = load_req && any_hit;
  assign cpu_rd = mem_rd;
`endif

  // Per-entry mask is only needed inside the matcher.
  logic unused_hit;
  assign unused_hit = ^{hit, youngest_idx};

  // Loads own the bus unless they are blocked behind a matching store,
  // in which case draining is how the block clears.
  assign drain_fire = rst_n && !is_empty && mem_ready &&
                      (!load_req || fwd_hazard_stall);
  assign enq_fire   = rst_n && cpu_we && (!is_full || drain_fire);

  assign mem_we    = drain_fire;
  assign mem_a     = drain_fire ? {entries[head].waddr, 2'b00} : cpu_a;
  assign mem_wd    = entries[head].data;
  assign cpu_stall = rst_n &&
                     ((cpu_we && is_full && !drain_fire) || fwd_hazard_stall);
  assign sb_empty  = !rst_n || is_empty;
  assign sb_full   = rst_n && is_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (drain_fire) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      // Enqueue after drain so a full-and-draining cycle refills the slot.
      if (enq_fire) begin
        entries[tail] <= '{waddr: query, data: cpu_wd};
        valid[tail]   <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      case ({enq_fire, drain_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_no_we_re : assert (!(cpu_we && cpu_re));
    end
  end

endmodule
